// File: rtl/mtm_alu.sv
// mtm_alu: 32-bit bit-serial ALU (AND/OR/ADD/SUB).
// Frames are 11 bits MSB first: start(0), type, 8 payload bits, stop(1).
// The response path is a two-stage pipeline (command latch, then result into
// a 1-deep pending slot), so the first response start bit leaves two clocks
// after the command stop bit has been sampled.
module mtm_alu (
    input  logic clk,
    input  logic rst_n,
    input  logic sin,
    output logic sout
);

    typedef enum logic [1:0] {RX_IDLE, RX_TYPE, RX_PAYLOAD, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_DATA, TX_CTL} tx_state_t;

    // CRC x^4+x+1, init 0, MSB first over {B, A, 1'b1, OP}
    function automatic logic [3:0] f_crc4(input logic [67:0] d);
        logic [3:0] c;
        logic       fb;
        c = 4'd0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ d[i];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        return c;
    endfunction

    // CRC x^3+x+1, init 0, MSB first over {C, 1'b0, FLAGS}
    function automatic logic [2:0] f_crc3(input logic [36:0] d);
        logic [2:0] c;
        logic       fb;
        c = 3'd0;
        for (int i = 36; i >= 0; i--) begin
            fb = c[2] ^ d[i];
            c  = {c[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
        end
        return c;
    endfunction

    rx_state_t   r_rx_state;
    logic        r_rx_type;
    logic [7:0]  r_rx_sh;
    logic [2:0]  r_rx_cnt;
    logic [3:0]  r_dcnt;        // saturates at 9: anything above 8 is just "not 8"
    logic [63:0] r_opnd;        // {B, A}, last 8 data bytes received
    logic        r_cmd_vld;
    logic [2:0]  r_cmd_op;
    logic [3:0]  r_cmd_crc;
    logic        r_cmd_cnt_ok;

    tx_state_t   r_tx_state;
    logic        r_sout;
    logic [9:0]  r_tx_sh;       // {type, payload, stop} still to be shifted out
    logic [3:0]  r_tx_bit;      // index of the frame bit currently on sout
    logic [1:0]  r_tx_byte;
    logic [31:0] r_tx_c;
    logic [7:0]  r_tx_ctl;
    logic        r_pend_vld;
    logic        r_pend_err;
    logic [31:0] r_pend_c;
    logic [7:0]  r_pend_ctl;

    logic [31:0] w_b, w_a, w_c;
    logic [32:0] w_sum33;
    logic        w_carry, w_ovf, w_op_bad;
    logic [3:0]  w_flags;
    logic [2:0]  w_err;
    logic [7:0]  w_ctl;
    logic        w_tx_load;

    assign w_b  = r_opnd[63:32];
    assign w_a  = r_opnd[31:0];
    assign sout = r_sout;

    // Receiver: frame deframing, operand shift register and command capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_state   <= RX_IDLE;
            r_rx_type    <= 1'b0;
            r_rx_sh      <= 8'd0;
            r_rx_cnt     <= 3'd0;
            r_dcnt       <= 4'd0;
            r_opnd       <= 64'd0;
            r_cmd_vld    <= 1'b0;
            r_cmd_op     <= 3'd0;
            r_cmd_crc    <= 4'd0;
            r_cmd_cnt_ok <= 1'b0;
        end else begin
            r_cmd_vld <= 1'b0;
            case (r_rx_state)
                RX_IDLE: if (!sin) r_rx_state <= RX_TYPE;
                RX_TYPE: begin
                    r_rx_type  <= sin;
                    r_rx_cnt   <= 3'd0;
                    r_rx_state <= RX_PAYLOAD;
                end
                RX_PAYLOAD: begin
                    r_rx_sh  <= {r_rx_sh[6:0], sin};
                    r_rx_cnt <= r_rx_cnt + 3'd1;
                    if (r_rx_cnt == 3'd7) r_rx_state <= RX_STOP;
                end
                RX_STOP: begin
                    r_rx_state <= RX_IDLE;
                    // a zero stop bit silently drops the frame
                    if (sin) begin
                        if (!r_rx_type) begin
                            r_opnd <= {r_opnd[55:0], r_rx_sh};
                            if (r_dcnt != 4'd9) r_dcnt <= r_dcnt + 4'd1;
                        end else begin
                            r_cmd_vld    <= 1'b1;
                            r_cmd_op     <= r_rx_sh[6:4];
                            r_cmd_crc    <= r_rx_sh[3:0];
                            r_cmd_cnt_ok <= (r_dcnt == 4'd8);
                            r_dcnt       <= 4'd0;
                        end
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // ALU datapath and flags for the latched command
    always_comb begin
        w_c      = 32'd0;
        w_sum33  = 33'd0;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        w_op_bad = 1'b0;
        case (r_cmd_op)
            3'b000: w_c = w_b & w_a;
            3'b001: w_c = w_b | w_a;
            3'b100: begin
                w_sum33 = {1'b0, w_b} + {1'b0, w_a};
                w_c     = w_sum33[31:0];
                w_carry = w_sum33[32];
                w_ovf   = (w_b[31] == w_a[31]) && (w_c[31] != w_b[31]);
            end
            3'b101: begin
                w_sum33 = {1'b0, w_b} - {1'b0, w_a};
                w_c     = w_sum33[31:0];
                w_carry = w_sum33[32];   // borrow: B < A unsigned
                w_ovf   = (w_b[31] != w_a[31]) && (w_c[31] != w_b[31]);
            end
            default: w_op_bad = 1'b1;
        endcase
        w_flags = {w_carry, w_ovf, (w_c == 32'd0), w_c[31]};
    end

    // Prioritised error select and control payload build
    always_comb begin
        w_err = 3'b000;
        if (!r_cmd_cnt_ok)                                 w_err = 3'b100;
        else if (f_crc4({r_opnd, 1'b1, r_cmd_op}) != r_cmd_crc) w_err = 3'b010;
        else if (w_op_bad)                                 w_err = 3'b001;
        if (w_err != 3'b000)
            w_ctl = {1'b1, w_err, w_err, ^{1'b1, w_err, w_err}};
        else
            w_ctl = {1'b0, w_flags, f_crc3({w_c, 1'b0, w_flags})};
    end

    assign w_tx_load = r_pend_vld &&
                       ((r_tx_state == TX_IDLE) ||
                        ((r_tx_state == TX_CTL) && (r_tx_bit == 4'd10)));

    // Pending slot and transmitter; frames follow each other with no idle bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
            r_sout     <= 1'b1;
            r_tx_sh    <= 10'd0;
            r_tx_bit   <= 4'd0;
            r_tx_byte  <= 2'd0;
            r_tx_c     <= 32'd0;
            r_tx_ctl   <= 8'd0;
            r_pend_vld <= 1'b0;
            r_pend_err <= 1'b0;
            r_pend_c   <= 32'd0;
            r_pend_ctl <= 8'd0;
        end else begin
            if (w_tx_load) begin
                r_pend_vld <= 1'b0;
                r_sout     <= 1'b0;
                r_tx_bit   <= 4'd0;
                r_tx_byte  <= 2'd0;
                r_tx_ctl   <= r_pend_ctl;
                if (r_pend_err) begin
                    r_tx_state <= TX_CTL;
                    r_tx_sh    <= {1'b1, r_pend_ctl, 1'b1};
                end else begin
                    r_tx_state <= TX_DATA;
                    r_tx_sh    <= {1'b0, r_pend_c[31:24], 1'b1};
                    r_tx_c     <= {r_pend_c[23:0], 8'd0};
                end
            end else if (r_tx_state == TX_IDLE) begin
                r_sout <= 1'b1;
            end else if (r_tx_bit != 4'd10) begin
                r_sout   <= r_tx_sh[9];
                r_tx_sh  <= {r_tx_sh[8:0], 1'b0};
                r_tx_bit <= r_tx_bit + 4'd1;
            end else if (r_tx_state == TX_DATA) begin
                r_sout   <= 1'b0;
                r_tx_bit <= 4'd0;
                if (r_tx_byte == 2'd3) begin
                    r_tx_state <= TX_CTL;
                    r_tx_sh    <= {1'b1, r_tx_ctl, 1'b1};
                end else begin
                    r_tx_byte <= r_tx_byte + 2'd1;
                    r_tx_sh   <= {1'b0, r_tx_c[31:24], 1'b1};
                    r_tx_c    <= {r_tx_c[23:0], 8'd0};
                end
            end else begin
                r_tx_state <= TX_IDLE;
                r_sout     <= 1'b1;
            end
            // a newly finished command overwrites the slot after any load above
            if (r_cmd_vld) begin
                r_pend_vld <= 1'b1;
                r_pend_err <= (w_err != 3'b000);
                r_pend_c   <= w_c;
                r_pend_ctl <= w_ctl;
            end
        end
    end

endmodule

// File: tb/tb_mtm_alu.sv
// tb_mtm_alu: directed vectors for the serial ALU with hand-computed results.
// Reference CRCs are computed by polynomial long division of the augmented message.
module tb_mtm_alu;

    logic clk;
    logic rst_n;
    logic sin;
    logic sout;

    int n_cmp;
    int n_bad;

    mtm_alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sin   (sin),
        .sout  (sout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // remainder of msg(x) * x^deg mod poly(x); poly includes its leading term
    function automatic logic [3:0] crc_div(input logic [67:0] msg, input int nbits,
                                           input int deg, input logic [4:0] poly);
        logic [75:0] v;
        logic [75:0] p;
        v = 76'(msg) << deg;
        p = 76'(poly);
        for (int i = nbits + deg - 1; i >= deg; i--)
            if (v[i]) v = v ^ (p << (i - deg));
        return v[3:0];
    endfunction

    task automatic send_pkt(input logic typ, input logic [7:0] b);
        logic [10:0] p;
        p = {1'b0, typ, b, 1'b1};
        for (int i = 10; i >= 0; i--) begin
            sin = p[i];
            @(posedge clk); #1;
        end
        sin = 1'b1;
    endtask

    // waits up to maxw edges for a start bit, then reads the 10 remaining bits
    task automatic recv_pkt(input int maxw, output int waited, output logic [9:0] tail);
        waited = -1;
        tail   = '1;
        for (int i = 1; i <= maxw && waited < 0; i++) begin
            @(posedge clk); #1;
            if (sout == 1'b0) waited = i;
        end
        if (waited > 0)
            for (int j = 9; j >= 0; j--) begin
                @(posedge clk); #1;
                tail[j] = sout;
            end
    endtask

    task automatic send_cmd(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                            input logic bad_crc, input int ndata);
        logic [63:0] v;
        logic [3:0]  crc;
        v   = {b, a};
        crc = crc_div({b, a, 1'b1, op}, 68, 4, 5'b10011);
        if (bad_crc) crc = crc ^ 4'h1;
        for (int i = 0; i < ndata; i++) send_pkt(1'b0, v[63 - 8*i -: 8]);
        send_pkt(1'b1, {1'b0, op, crc});
    endtask

    task automatic run_cmd(input string name, input logic [31:0] b, input logic [31:0] a,
                           input logic [2:0] op, input logic bad_crc, input int ndata,
                           input logic exp_err, input logic [31:0] exp_c,
                           input logic [3:0] exp_flags, input logic [7:0] exp_err_pl);
        int         w;
        int         zeros;
        logic [9:0] t;
        logic [2:0] crc3;
        send_cmd(b, a, op, bad_crc, ndata);
        recv_pkt(20, w, t);
        chk({name, " latency"}, 64'(w), 64'd2);
        if (exp_err) begin
            chk({name, " err ctl"}, 64'(t), 64'({1'b1, exp_err_pl, 1'b1}));
        end else begin
            chk({name, " byte0"}, 64'(t), 64'({1'b0, exp_c[31:24], 1'b1}));
            for (int k = 1; k < 4; k++) begin
                recv_pkt(3, w, t);
                chk({name, " gap"}, 64'(w), 64'd1);
                chk({name, " byte"}, 64'(t), 64'({1'b0, exp_c[31 - 8*k -: 8], 1'b1}));
            end
            crc3 = crc_div({31'd0, exp_c, 1'b0, exp_flags}, 37, 3, 5'b01011);
            recv_pkt(3, w, t);
            chk({name, " ctl gap"}, 64'(w), 64'd1);
            chk({name, " ctl"}, 64'(t), 64'({1'b1, 1'b0, exp_flags, crc3, 1'b1}));
        end
        zeros = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (sout == 1'b0) zeros++;
        end
        chk({name, " idle after"}, 64'(zeros), 64'd0);
    endtask

    initial begin
        int         w;
        int         zeros;
        logic [9:0] t;
        n_cmp = 0;
        n_bad = 0;
        sin   = 1'b1;
        rst_n = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset sout", 64'(sout), 64'd1);
        rst_n = 1'b1;
        zeros = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (sout == 1'b0) zeros++;
        end
        chk("idle after reset", 64'(zeros), 64'd0);

        run_cmd("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 1'b0, 8, 1'b0,
                32'h0000_0000, 4'b1010, 8'h00);
        run_cmd("sub_borrow", 32'h0000_0000, 32'h0000_0001, 3'b101, 1'b0, 8, 1'b0,
                32'hFFFF_FFFF, 4'b1001, 8'h00);
        run_cmd("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 3'b100, 1'b0, 8, 1'b0,
                32'h8000_0000, 4'b0101, 8'h00);
        run_cmd("and", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 1'b0, 8, 1'b0,
                32'hF000_F000, 4'b0001, 8'h00);
        run_cmd("or", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b001, 1'b0, 8, 1'b0,
                32'hFFF0_FFF0, 4'b0001, 8'h00);
        run_cmd("err_op", 32'h1234_5678, 32'h9ABC_DEF0, 3'b010, 1'b0, 8, 1'b1,
                32'h0, 4'h0, 8'h93);
        run_cmd("err_crc", 32'h1234_5678, 32'h9ABC_DEF0, 3'b100, 1'b1, 8, 1'b1,
                32'h0, 4'h0, 8'hA5);
        run_cmd("err_data", 32'h1234_5678, 32'h9ABC_DEF0, 3'b100, 1'b0, 7, 1'b1,
                32'h0, 4'h0, 8'hC9);

        // reset in the middle of the second response data packet
        send_cmd(32'h0000_0010, 32'h0000_0020, 3'b100, 1'b0, 8);
        recv_pkt(20, w, t);
        chk("rst_mid first pkt", 64'(t), 64'({1'b0, 8'h00, 1'b1}));
        @(posedge clk); #1;
        chk("rst_mid second start", 64'(sout), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid sout 1st", 64'(sout), 64'd1);
        @(posedge clk); #1;
        chk("rst_mid sout 2nd", 64'(sout), 64'd1);
        rst_n = 1'b1;
        zeros = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (sout == 1'b0) zeros++;
        end
        chk("rst_mid quiet", 64'(zeros), 64'd0);

        run_cmd("sub_after_rst", 32'h0000_0005, 32'h0000_0003, 3'b101, 1'b0, 8, 1'b0,
                32'h0000_0002, 4'b0000, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
